pc_4: RTL

PC_4 -- requirements
Module: pc_4

---
 rtl/pc_4_pkg.sv | 13 +
 rtl/pc_4_mux2_4.sv | 13 +
 rtl/pc_4.sv | 99 +++++++++
 3 files changed

// File: rtl/pc_4_pkg.sv
// Shared definitions for the pc_4 program counter: PC width, wrap value and FSM state encoding.
package pc_4_pkg;

  localparam int PC_W = 4;
  localparam logic [PC_W-1:0] PC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_e;

endpackage

// File: rtl/pc_4_mux2_4.sv
// mux2_4: 4-bit two-way select used for the next-PC choice (s=0 -> a, s=1 -> b).
module mux2_4
  import pc_4_pkg::*;
(
  input  logic [PC_W-1:0] a,
  input  logic [PC_W-1:0] b,
  input  logic            s,
  output logic [PC_W-1:0] out
);

  assign out = s ? b : a;

endmodule

// File: rtl/pc_4.sv
// pc_4: 4-bit program counter offered downstream over valid/ready, sequenced by IDLE/RUN/HALT.
// Build option PC_JMPCNT_EN adds the saturating taken-jump counter on port jmp_cnt.
//
// state | meaning
// IDLE  | waiting for en; pc held at RESET_PC
// RUN   | pc offered (valid=1); advances on each accepted transfer
// HALT  | pc frozen until resume without halt_req
module pc_4
  import pc_4_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 4'b0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            jump,
  input  logic [PC_W-1:0] target,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            ready,
  output logic [PC_W-1:0] pc,
  output logic            valid,
  output logic [1:0]      state,
`ifdef PC_JMPCNT_EN
  output logic [PC_W-1:0] jmp_cnt,
`endif
  output logic            wrap
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc, pc_next;
  logic            wrap_q, wrap_d;
  logic            xfer;

  assign xfer   = (state_q == RUN) && ready;
  assign pc_inc = pc_q + PC_W'(1);

  mux2_4 u_next_mux (
    .a   (pc_inc),
    .b   (target),
    .s   (jump),
    .out (pc_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (halt_req) state_d = HALT;
      // halt_req has priority so a simultaneous resume cannot escape HALT
      HALT:    if (resume && !halt_req) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (xfer) begin
      pc_d   = pc_next;
      wrap_d = !jump && (pc_q == PC_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef PC_JMPCNT_EN
  logic [PC_W-1:0] jmp_cnt_q, jmp_cnt_d;

  always_comb begin
    jmp_cnt_d = jmp_cnt_q;
    if (xfer && jump && (jmp_cnt_q != PC_MAX)) jmp_cnt_d = jmp_cnt_q + PC_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) jmp_cnt_q <= '0;
    else       jmp_cnt_q <= jmp_cnt_d;
  end

  assign jmp_cnt = jmp_cnt_q;
`endif

  assign pc    = pc_q;
  assign valid = (state_q == RUN);
  assign state = state_q;
  assign wrap  = wrap_q;

endmodule
